// File: rtl/control_unit_pkg.sv
// Shared opcode, ALU-op, FSM state and instruction-field definitions for the core sequencer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package control_unit_pkg;

  localparam int M = 3;
  localparam int N = 16;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_XOR  = 4'h4;
  localparam logic [3:0] OPC_NOT  = 4'h5;
  localparam logic [3:0] OPC_MOV  = 4'h6;
  localparam logic [3:0] OPC_NOP  = 4'h7;
  localparam logic [3:0] OPC_LD   = 4'h8;
  localparam logic [3:0] OPC_ST   = 4'h9;
  localparam logic [3:0] OPC_LDI  = 4'hA;
  localparam logic [3:0] OPC_BRZ  = 4'hB;
  localparam logic [3:0] OPC_BRN  = 4'hC;
  localparam logic [3:0] OPC_BRO  = 4'hD;
  localparam logic [3:0] OPC_BRA  = 4'hE;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;
  localparam logic [2:0] ALU_INC = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM9_MSB  = 8;
  localparam int IMM12_MSB = 11;

  typedef enum logic [2:0] {
    ST_FETCH, ST_EXEC, ST_WB, ST_MADDR, ST_MEXEC2, ST_MDATA, ST_HALT
  } state_e;

  typedef struct packed {
    logic [M-1:0] waddr;
    logic [M-1:0] ra;
    logic [M-1:0] rb;
    logic [2:0]   op;
    logic         ie;
    logic         write;
    logic         reada;
    logic         readb;
    logic         en;
    logic         oe;
    logic         data_en;
    logic         addr_en;
    logic         bypassa;
    logic         bypassb;
    logic         mov_sel;
    logic         dmem_ale;
    logic         dmem_re;
    logic         dmem_we;
    logic         halted;
    logic [N-1:0] offset;
  } ctrl_t;

  function automatic logic [N-1:0] sext9(input logic [N-1:0] ir);
    return {{(N-IMM9_MSB-1){ir[IMM9_MSB]}}, ir[IMM9_MSB:0]};
  endfunction

  function automatic logic [N-1:0] sext12(input logic [N-1:0] ir);
    return {{(N-IMM12_MSB-1){ir[IMM12_MSB]}}, ir[IMM12_MSB:0]};
  endfunction

endpackage

// File: rtl/control_unit_instr_decode.sv
// Moore strobe decode: FSM state plus captured IR -> every datapath/dmem control.
// Latency: combinational.
// Backpressure: none; outputs depend only on registered state.
module instr_decode
  import control_unit_pkg::*;
(
  input  state_e       state,
  input  logic [N-1:0] ir,
  output ctrl_t        ctrl
);

  logic [3:0]   opc;
  logic [M-1:0] rd, rs1, rs2;

  assign opc = ir[OPC_MSB:OPC_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs1 = ir[RS1_MSB:RS1_LSB];
  assign rs2 = ir[RS2_MSB:RS2_LSB];

  always_comb begin
    ctrl = '0;
    case (state)
      ST_EXEC: begin
        case (opc)
          OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: begin
            ctrl.ra    = rs1;
            ctrl.rb    = rs2;
            ctrl.reada = 1'b1;
            ctrl.readb = 1'b1;
            ctrl.op    = opc[2:0];
            ctrl.en    = 1'b1;
          end
          OPC_NOT: begin
            ctrl.ra    = rs1;
            ctrl.reada = 1'b1;
            ctrl.op    = ALU_NOT;
            ctrl.en    = 1'b1;
          end
          // LD/ST push the address register through the ALU before MADDR
          OPC_MOV, OPC_LD, OPC_ST: begin
            ctrl.ra      = rs1;
            ctrl.reada   = 1'b1;
            ctrl.op      = ALU_MOV;
            ctrl.mov_sel = 1'b1;
            ctrl.en      = 1'b1;
          end
          OPC_LDI: begin
            ctrl.bypassa = 1'b1;
            ctrl.op      = ALU_MOV;
            ctrl.mov_sel = 1'b1;
            ctrl.en      = 1'b1;
            ctrl.offset  = sext9(ir);
          end
          default: ;
        endcase
      end
      ST_WB: begin
        ctrl.waddr = rd;
        ctrl.write = 1'b1;
        ctrl.ie    = (opc == OPC_LD);
      end
      ST_MADDR: begin
        ctrl.oe       = 1'b1;
        ctrl.addr_en  = 1'b1;
        ctrl.dmem_ale = 1'b1;
        ctrl.dmem_re  = (opc == OPC_LD);
      end
      ST_MEXEC2: begin
        ctrl.rb      = rs2;
        ctrl.readb   = 1'b1;
        ctrl.op      = ALU_MOV;
        ctrl.mov_sel = 1'b0;
        ctrl.en      = 1'b1;
      end
      ST_MDATA: begin
        ctrl.oe      = 1'b1;
        ctrl.data_en = 1'b1;
        ctrl.dmem_we = 1'b1;
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch/decode/FSM and PC, driving the register-file/ALU datapath.
// Latency: 2 (branch/NOP), 3 (ALU/MOV/LDI), 4 (LD), 5 (ST) cycles per instruction.
// Backpressure: none; data memory must return read data in the cycle after dmem_ale.
module control_unit
  import control_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] instr,
  input  logic         o_flag,
  input  logic         z_flag,
  input  logic         n_flag,
  output logic [N-1:0] pc,
  output logic [M-1:0] waddr,
  output logic [M-1:0] ra,
  output logic [M-1:0] rb,
  output logic [2:0]   op,
  output logic         ie,
  output logic         write,
  output logic         reada,
  output logic         readb,
  output logic         en,
  output logic         oe,
  output logic         data_en,
  output logic         addr_en,
  output logic         bypassa,
  output logic         bypassb,
  output logic         mov_sel,
  output logic [N-1:0] offset,
  output logic         dmem_ale,
  output logic         dmem_re,
  output logic         dmem_we,
  output logic         halted
);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] ir_q, ir_d;
  logic [3:0]   opc;
  logic         pc_upd, taken;
  ctrl_t        ctrl;

  assign opc = ir_q[OPC_MSB:OPC_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_upd  = 1'b0;
    ir_d    = ir_q;
    taken   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opc)
          OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_NOT, OPC_MOV, OPC_LDI:
            state_d = ST_WB;
          OPC_LD, OPC_ST: state_d = ST_MADDR;
          OPC_HALT:       state_d = ST_HALT;
          default: begin
            state_d = ST_FETCH;
            pc_upd  = 1'b1;
          end
        endcase
        // flags here are the ones registered on the most recent en=1 edge
        case (opc)
          OPC_BRZ: taken = z_flag;
          OPC_BRN: taken = n_flag;
          OPC_BRO: taken = o_flag;
          OPC_BRA: taken = 1'b1;
          default: taken = 1'b0;
        endcase
      end
      ST_WB: begin
        state_d = ST_FETCH;
        pc_upd  = 1'b1;
      end
      ST_MADDR:  state_d = (opc == OPC_LD) ? ST_WB : ST_MEXEC2;
      ST_MEXEC2: state_d = ST_MDATA;
      ST_MDATA: begin
        state_d = ST_FETCH;
        pc_upd  = 1'b1;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
    pc_d = pc_upd ? (pc_q + N'(1) + (taken ? sext12(ir_q) : '0)) : pc_q;
  end

  instr_decode u_decode (
    .state (state_q),
    .ir    (ir_q),
    .ctrl  (ctrl)
  );

  always_comb begin
    pc       = pc_q;
    waddr    = ctrl.waddr;
    ra       = ctrl.ra;
    rb       = ctrl.rb;
    op       = ctrl.op;
    ie       = ctrl.ie;
    write    = ctrl.write;
    reada    = ctrl.reada;
    readb    = ctrl.readb;
    en       = ctrl.en;
    oe       = ctrl.oe;
    data_en  = ctrl.data_en;
    addr_en  = ctrl.addr_en;
    bypassa  = ctrl.bypassa;
    bypassb  = ctrl.bypassb;
    mov_sel  = ctrl.mov_sel;
    offset   = ctrl.offset;
    dmem_ale = ctrl.dmem_ale;
    dmem_re  = ctrl.dmem_re;
    dmem_we  = ctrl.dmem_we;
    halted   = ctrl.halted;
  end

endmodule
